// File: rtl/pet_pkg.sv
// Shared definitions for the pet needs engine: top-level state encoding
// and the default parameter values used by every module in this slice.
package pet_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        TEST  = 2'd1,
        DEAD  = 2'd2
    } top_state_e;

    localparam int DEF_NUM_NEEDS   = 4;
    localparam int DEF_LVL_W       = 3;
    localparam int DEF_LVL_MAX     = 5;
    localparam int DEF_CLK_PER_SEC = 50;
    localparam int DEF_PER_W       = 7;
    localparam int DEF_LOW_THR     = 2;
    localparam int DEF_HARM_PER    = 10;

endpackage

// File: rtl/pet_needs_engine_need_channel.sv
// One need channel: a level in 1..LVL_MAX plus a seconds timer that
// drives periodic decay. Care raises the level, test-mode inc/dec nudge
// it, and force_zero pins it to 0 once the pet has died.
module need_channel
    import pet_pkg::*;
#(
    parameter int LVL_W   = DEF_LVL_W,
    parameter int LVL_MAX = DEF_LVL_MAX,
    parameter int PER_W   = DEF_PER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic [PER_W-1:0] decay_per,
    input  logic             run_en,
    input  logic             test_en,
    input  logic             care,
    input  logic             inc,
    input  logic             dec,
    input  logic             force_zero,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    logic [LVL_W-1:0] level_q, level_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic             decay_on;
    logic             decay_ev;

    // A period of 0 turns decay off; >= guards against a period shrunk
    // below the current timer value.
    assign decay_on = (decay_per != '0);
    assign decay_ev = sec_tick && decay_on && (timer_q >= decay_per - PER_W'(1));

    // Next level/timer: death overrides all, then ALIVE care/decay, then test nudges.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        timer_d = timer_q;
        if (force_zero) begin
            level_d = '0;
        end else if (run_en) begin
            if (care) begin
                // Care beats a coincident decay event and restarts the period.
                if (level_q < LVL_FULL) level_d = level_q + LVL_ONE;
                timer_d = '0;
            end else if (decay_ev) begin
                if (level_q > LVL_ONE) level_d = level_q - LVL_ONE;
                timer_d = '0;
            end else if (sec_tick && decay_on) begin
                timer_d = timer_q + PER_W'(1);
            end
        end else if (test_en) begin
            if (inc && !dec && (level_q < LVL_FULL)) begin
                level_d = level_q + LVL_ONE;
            end else if (dec && !inc && (level_q > LVL_ONE)) begin
                level_d = level_q - LVL_ONE;
            end
        end
    end

    // Level and timer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            level_q <= LVL_FULL;
            timer_q <= '0;
        end else begin
            level_q <= level_d;
            timer_q <= timer_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/pet_needs_engine.sv
// Virtual pet needs engine: a seconds prescaler, NUM_NEEDS decaying need
// channels, a health level worn down by prolonged critical need, and a
// top FSM (ALIVE / TEST / DEAD) with a test mode for manual adjustment.
module pet_needs_engine
    import pet_pkg::*;
#(
    parameter int NUM_NEEDS   = DEF_NUM_NEEDS,
    parameter int LVL_W       = DEF_LVL_W,
    parameter int LVL_MAX     = DEF_LVL_MAX,
    parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
    parameter int PER_W       = DEF_PER_W,
    parameter int LOW_THR     = DEF_LOW_THR,
    parameter int HARM_PER    = DEF_HARM_PER
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_NEEDS*PER_W-1:0]           decay_per,
    input  logic [NUM_NEEDS-1:0]                 care,
    input  logic                                 heal,
    input  logic                                 test_tgl,
    input  logic                                 sel_next,
    input  logic                                 inc,
    input  logic                                 dec,
    output logic [NUM_NEEDS*LVL_W-1:0]           levels,
    output logic [LVL_W-1:0]                     health,
    output logic                                 dead,
    output logic                                 test_mode,
    output logic [$clog2(NUM_NEEDS+1)-1:0]       sel,
    output logic                                 sec_tick
);

    localparam int SEL_W  = $clog2(NUM_NEEDS + 1);
    localparam int PRE_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int HARM_W = $clog2(HARM_PER + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [HARM_W-1:0] HARM_LAST  = HARM_W'(HARM_PER - 1);
    localparam logic [SEL_W-1:0]  SEL_HEALTH = SEL_W'(NUM_NEEDS);
    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_LOW    = LVL_W'(LOW_THR);

    top_state_e        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              sec_tick_q, sec_tick_d;
    logic [HARM_W-1:0] harm_q, harm_d;
    logic [LVL_W-1:0]  health_q, health_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              any_low;
    logic              harm_hit;
    logic              health_sel;

    assign health_sel = (sel_q == SEL_HEALTH);

    // Prescaler wraps at CLK_PER_SEC-1; the tick flop is high while the count sits there.
    always_comb begin
        pre_d      = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        sec_tick_d = (pre_d == PRE_LAST);
    end

    // Any channel at or below the critical threshold keeps the harm counter running.
    always_comb begin
        any_low = 1'b0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            if (levels[i*LVL_W +: LVL_W] <= LVL_LOW) any_low = 1'b1;
        end
    end

    // Harm counter and health: harm wears health down, heal wins a same-cycle tie.
    always_comb begin
        harm_d   = harm_q;
        harm_hit = 1'b0;
        health_d = health_q;
        unique case (state_q)
            ALIVE: begin
                if (!any_low) begin
                    harm_d = '0;
                end else if (sec_tick_q) begin
                    if (harm_q >= HARM_LAST) begin
                        harm_d   = '0;
                        harm_hit = 1'b1;
                    end else begin
                        harm_d = harm_q + HARM_W'(1);
                    end
                end
                if (heal) begin
                    if (health_q < LVL_FULL) health_d = health_q + LVL_ONE;
                end else if (harm_hit) begin
                    health_d = health_q - LVL_ONE;
                end
            end
            TEST: begin
                if (health_sel) begin
                    if (inc && !dec && (health_q < LVL_FULL)) begin
                        health_d = health_q + LVL_ONE;
                    end else if (dec && !inc && (health_q > LVL_ONE)) begin
                        health_d = health_q - LVL_ONE;
                    end
                end
            end
            DEAD: begin
                health_d = '0;
            end
            default: begin
                health_d = health_q;
            end
        endcase
    end

    // Top FSM next state: death is checked before the test toggle and is terminal.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ALIVE: begin
                if (health_d == '0) begin
                    state_d = DEAD;
                end else if (test_tgl) begin
                    state_d = TEST;
                end
            end
            TEST: begin
                if (test_tgl) state_d = ALIVE;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
    end

    // Selector steps through the channels then health, only while in test mode.
    always_comb begin
        sel_d = sel_q;
        if ((state_q == TEST) && sel_next) begin
            sel_d = health_sel ? '0 : sel_q + SEL_W'(1);
        end
    end

    // Engine registers; reset overrides every other input on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ALIVE;
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
            harm_q     <= '0;
            health_q   <= LVL_FULL;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            sec_tick_q <= sec_tick_d;
            harm_q     <= harm_d;
            health_q   <= health_d;
            sel_q      <= sel_d;
        end
    end

    // Channels are zeroed on the same edge the FSM enters DEAD.
    for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_ch
        need_channel #(
            .LVL_W   (LVL_W),
            .LVL_MAX (LVL_MAX),
            .PER_W   (PER_W)
        ) u_need_channel (
            .clk        (clk),
            .rst        (rst),
            .sec_tick   (sec_tick_q),
            .decay_per  (decay_per[gi*PER_W +: PER_W]),
            .run_en     (state_q == ALIVE),
            .test_en    (state_q == TEST),
            .care       (care[gi]),
            .inc        (inc && (sel_q == SEL_W'(gi))),
            .dec        (dec && (sel_q == SEL_W'(gi))),
            .force_zero (state_d == DEAD),
            .level      (levels[gi*LVL_W +: LVL_W])
        );
    end

    assign health    = health_q;
    assign dead      = (state_q == DEAD);
    assign test_mode = (state_q == TEST);
    assign sel       = sel_q;
    assign sec_tick  = sec_tick_q;

endmodule

// File: doc/pet_needs_engine.md
PET_NEEDS_ENGINE -- requirements
Module: pet_needs_engine

Interface
REQ-001 Parameter NUM_NEEDS, default 4, number of need channels (2..8).
REQ-002 Parameter LVL_W, default 3, level width in bits.
REQ-003 Parameter LVL_MAX, default 5, full level; must be at most 2**LVL_W-1.
REQ-004 Parameter CLK_PER_SEC, default 50, clocks per second tick (50000000 on FPGA).
REQ-005 Parameter PER_W, default 7, width of per-channel period fields.
REQ-006 Parameter LOW_THR, default 2, a need at or below this level is critical.
REQ-007 Parameter HARM_PER, default 10, seconds of continuous critical need per health decrement.
REQ-008 clk  input  1  clock.
REQ-009 rst  input  1  synchronous, active-low reset.
REQ-010 decay_per  input  NUM_NEEDS*PER_W  seconds between decrements per channel; channel i occupies bits [i*PER_W +: PER_W]; 0 disables decay.
REQ-011 care  input  NUM_NEEDS  one-cycle pulse per channel; raises that need.
REQ-012 heal  input  1  one-cycle pulse; raises health.
REQ-013 test_tgl  input  1  pulse; toggles test mode.
REQ-014 sel_next  input  1  pulse; advances the test-mode selector.
REQ-015 inc, dec  input  1 each  test-mode pulses acting on the selected channel.
REQ-016 levels  output  NUM_NEEDS*LVL_W  need levels, packed like decay_per.
REQ-017 health  output  LVL_W  health level.
REQ-018 dead, test_mode  output  1 each  status flags.
REQ-019 sel  output  clog2(NUM_NEEDS+1)  selected channel; value NUM_NEEDS selects health.
REQ-020 sec_tick  output  1  one-cycle pulse per second.

Function
REQ-021 Prescaler counts 0..CLK_PER_SEC-1 and wraps; sec_tick is high in the cycle the count equals CLK_PER_SEC-1.
REQ-022 Top FSM states: ALIVE, TEST, DEAD.
- ALIVE->TEST on test_tgl; TEST->ALIVE on test_tgl.
- ALIVE->DEAD when health becomes 0.
- DEAD is left only by reset; no transition out of TEST to DEAD.
REQ-023 ALIVE, per channel:
- A seconds timer advances on sec_tick.
- On the sec_tick where the timer equals decay_per-1, level decrements (floor 1) and the timer clears.
REQ-024 ALIVE, care[i]: level i increments, saturating at LVL_MAX, and timer i clears, effective the next cycle.
REQ-025 care[i] and a decay event on the same cycle: care wins; level +1, no decrement, timer clears.
REQ-026 Harm counter, ALIVE only:
- Advances on sec_tick while any level <= LOW_THR; otherwise clears.
- On reaching HARM_PER-1 at a sec_tick, health decrements by 1 (no floor) and the counter clears.
REQ-027 heal in ALIVE: health +1, saturating at LVL_MAX.
- heal wins over a same-cycle harm decrement.
- The harm counter is not cleared by heal.
REQ-028 DEAD: all levels and health are forced to 0, dead=1, and all inputs are ignored.
REQ-029 TEST:
- Decay, harm, care and heal are frozen or ignored; timers hold.
- sel_next advances sel, wrapping NUM_NEEDS->0.
- inc or dec adjusts the selected level by ±1 within 1..LVL_MAX.
- inc and dec together: no change.
REQ-030 Exiting TEST resumes timers from their held values; sel holds its value across mode changes.
REQ-031 Outputs are registered; every state change is visible one cycle after the causing input edge.

Reset
REQ-032 On rst=0 at a clock edge:
- All levels and health = LVL_MAX.
- Timers, prescaler, harm counter and sel = 0.
- State = ALIVE; dead=0, test_mode=0, sec_tick=0.
REQ-033 Reset mid-operation, including in DEAD or TEST, takes effect on that edge and overrides every other input.

Structure
REQ-034 Package pet_pkg holds the top-state enum (ALIVE, TEST, DEAD) and default parameter constants.
REQ-035 One sub-module, need_channel, holds one level plus its timer with decay, care, test inc/dec and force-zero inputs; it is instantiated NUM_NEEDS times via generate.

Verification
REQ-036 NUM_NEEDS=4, CLK_PER_SEC=4, decay_per ch0=3, no care: levels[0] reads 5,4,3,2,1 at 3-second steps and then holds at 1.
REQ-037 care[0] pulsed in the same cycle as ch0's decay event at level 3 -> level 4, and the next decrement occurs 3 seconds later.
REQ-038 All channels held at 1, HARM_PER=10 -> health decrements every 10 seconds; at health 0, dead=1 and all outputs are 0; care, heal and test_tgl then have no effect.
REQ-039 test_tgl, sel_next x4 (sel=4, health), dec x2 -> health 3; inc at level 5 stays 5; seconds elapse with no decay; test_tgl -> decay resumes.
REQ-040 rst=0 asserted while in DEAD and while in TEST -> next cycle all levels 5, state ALIVE, sel=0.
